// File: rtl/pulpino_boot_seq.sv
// Boot/reset sequencer for the PULPino FPGA top: synchronises the MMCM lock,
// debounces the board reset button, holds the core in reset for a fixed time,
// then releases reset and raises fetch enable. Also handles a software soft
// reset and reports the cause of the most recent reset entry.
module pulpino_boot_seq #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned DEBOUNCE_CYCLES    = 100000,
    parameter int unsigned RST_HOLD_CYCLES    = 64,
    parameter int unsigned FETCH_DELAY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked_i,
    input  logic       ext_rst_n_i,
    input  logic       sw_rst_req_i,
    output logic       core_rst_n_o,
    output logic       fetch_enable_o,
    output logic [1:0] state_o,
    output logic [1:0] rst_cause_o
);

    localparam int unsigned MAX_HF  = (RST_HOLD_CYCLES > FETCH_DELAY_CYCLES) ?
                                      RST_HOLD_CYCLES : FETCH_DELAY_CYCLES;
    localparam int unsigned MAX_CNT = (DEBOUNCE_CYCLES > MAX_HF) ? DEBOUNCE_CYCLES : MAX_HF;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR    = 2'd0,
        CAUSE_LOCK   = 2'd1,
        CAUSE_BUTTON = 2'd2,
        CAUSE_SOFT   = 2'd3
    } cause_e;

    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q,  btn_sync_d;
    logic                   lock_s, btn_s;

    logic                   btn_deb_q, btn_deb_d;
    logic [CNT_W-1:0]       db_cnt_q,  db_cnt_d;

    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   fetch_en_q,   fetch_en_d;

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s  = btn_sync_q[SYNC_STAGES-1];

    // Shift the asynchronous lock and button inputs through their synchronisers
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked_i};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], ext_rst_n_i};
    end

    // Debounce: adopt the synchronised button only after it differs long enough
    always_comb begin
        btn_deb_d = btn_deb_q;
        db_cnt_d  = db_cnt_q;
        if (btn_s == btn_deb_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_deb_d = btn_s;
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
        end
    end

    // Sequencer next state; exit events first in priority lock > button > soft
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            cause_d = CAUSE_LOCK;
        end else if ((state_q == RELEASE || state_q == RUN) && !btn_deb_q) begin
            state_d = HOLD;
            cnt_d   = '0;
            cause_d = CAUSE_BUTTON;
        end else if ((state_q == RELEASE || state_q == RUN) && sw_rst_req_i) begin
            state_d = HOLD;
            cnt_d   = '0;
            cause_d = CAUSE_SOFT;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s && btn_deb_q) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (!btn_deb_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == FETCH_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs follow the next state so they are registered alongside it
        core_rst_n_d = (state_d == RELEASE) || (state_d == RUN);
        fetch_en_d   = (state_d == RUN);
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync_q  <= '0;
            btn_sync_q   <= '0;
            btn_deb_q    <= 1'b1;
            db_cnt_q     <= '0;
            state_q      <= WAIT_LOCK;
            cause_q      <= CAUSE_POR;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
            fetch_en_q   <= 1'b0;
        end else begin
            lock_sync_q  <= lock_sync_d;
            btn_sync_q   <= btn_sync_d;
            btn_deb_q    <= btn_deb_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            cause_q      <= cause_d;
            cnt_q        <= cnt_d;
            core_rst_n_q <= core_rst_n_d;
            fetch_en_q   <= fetch_en_d;
        end
    end

    assign core_rst_n_o   = core_rst_n_q;
    assign fetch_enable_o = fetch_en_q;
    assign state_o        = state_q;
    assign rst_cause_o    = cause_q;

endmodule

// File: tb/tb_pulpino_boot_seq.sv
// Self-checking bench for pulpino_boot_seq: directed scenarios plus a random
// run, all compared against a deadline-based behavioural model.
module tb_pulpino_boot_seq;

    localparam int SYNC  = 2;
    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int FETCH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_i = 1'b0;
    logic       ext_rst_n_i = 1'b1;
    logic       sw_rst_req_i = 1'b0;
    logic       core_rst_n_o;
    logic       fetch_enable_o;
    logic [1:0] state_o;
    logic [1:0] rst_cause_o;
    logic [5:0] dut_vec;

    int n_checks = 0;
    int n_err    = 0;

    pulpino_boot_seq #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DB),
        .RST_HOLD_CYCLES   (HOLD),
        .FETCH_DELAY_CYCLES(FETCH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked_i      (locked_i),
        .ext_rst_n_i   (ext_rst_n_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .core_rst_n_o  (core_rst_n_o),
        .fetch_enable_o(fetch_enable_o),
        .state_o       (state_o),
        .rst_cause_o   (rst_cause_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state_o, rst_cause_o, core_rst_n_o, fetch_enable_o};

    // Behavioural model: phases advance on absolute edge deadlines; debounce
    // counts consecutive disagreeing samples; synchronisers are shift arrays.
    int now = 0;
    int m_phase = 0;
    int m_cause = 0;
    bit m_deb = 1'b1;
    int m_mm = 0;
    int m_due = 0;
    int m_fdue = 0;
    bit m_lk [SYNC];
    bit m_bt [SYNC];

    always @(posedge clk) begin
        bit ls, bs;
        int np, nc;
        now++;
        if (rst) begin
            m_phase = 0; m_cause = 0; m_deb = 1'b1; m_mm = 0;
            for (int i = 0; i < SYNC; i++) begin m_lk[i] = 1'b0; m_bt[i] = 1'b0; end
        end else begin
            ls = m_lk[SYNC-1];
            bs = m_bt[SYNC-1];
            np = m_phase;
            nc = m_cause;
            if (m_phase != 0 && !ls) begin
                np = 0; nc = 1;
            end else if (m_phase >= 2 && !m_deb) begin
                np = 1; nc = 2; m_due = now + HOLD;
            end else if (m_phase >= 2 && sw_rst_req_i) begin
                np = 1; nc = 3; m_due = now + HOLD;
            end else if (m_phase == 0) begin
                if (ls && m_deb) begin np = 1; m_due = now + HOLD; end
            end else if (m_phase == 1) begin
                if (!m_deb) m_due = now + HOLD;
                else if (now == m_due) begin np = 2; m_fdue = now + FETCH; end
            end else if (m_phase == 2) begin
                if (now == m_fdue) np = 3;
            end
            if (bs == m_deb) m_mm = 0;
            else begin
                m_mm++;
                if (m_mm == DB) begin m_deb = bs; m_mm = 0; end
            end
            for (int i = SYNC - 1; i > 0; i--) begin m_lk[i] = m_lk[i-1]; m_bt[i] = m_bt[i-1]; end
            m_lk[0] = locked_i;
            m_bt[0] = ext_rst_n_i;
            m_phase = np;
            m_cause = nc;
        end
    end

    function automatic logic [5:0] model_vec();
        return {2'(m_phase), 2'(m_cause), (m_phase >= 2), (m_phase == 3)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; locked_i = 1'b0; ext_rst_n_i = 1'b1; sw_rst_req_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== 6'b00_00_0_0) begin
                n_err++;
                $display("FAIL reset_values got=%b want=%b", dut_vec, 6'b00_00_0_0);
            end
        end
    endtask

    task automatic test_clean_boot();
        int rise_n = -1;
        int fe_n = -1;
        logic [1:0] seq[$];
        logic [7:0] seq_p;
        rst = 1'b0; locked_i = 1'b1; ext_rst_n_i = 1'b1;
        seq.push_back(state_o);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_err++;
                $display("FAIL boot_model edge=%0d got=%b want=%b", n, dut_vec, model_vec());
            end
            if (core_rst_n_o && rise_n < 0) rise_n = n;
            if (fetch_enable_o && fe_n < 0) fe_n = n;
            if (state_o != seq[$]) seq.push_back(state_o);
        end
        n_checks++;
        if (rise_n != SYNC + 1 + HOLD) begin
            n_err++; $display("FAIL boot_rst_rise got=%0d want=%0d", rise_n, SYNC + 1 + HOLD);
        end
        n_checks++;
        if (fe_n != SYNC + 1 + HOLD + FETCH) begin
            n_err++; $display("FAIL boot_fetch_rise got=%0d want=%0d", fe_n, SYNC + 1 + HOLD + FETCH);
        end
        seq_p = (seq.size() == 4) ? {seq[0], seq[1], seq[2], seq[3]} : 8'hxx;
        n_checks++;
        if (seq_p !== 8'b00_01_10_11) begin
            n_err++; $display("FAIL boot_state_seq got=%b len=%0d want=00011011", seq_p, seq.size());
        end
        n_checks++;
        if (rst_cause_o !== 2'd0) begin
            n_err++; $display("FAIL boot_cause got=%0d want=0", rst_cause_o);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 24; i++) begin
            ext_rst_n_i = (i >= 20) ? 1'b1 : 1'((i / 2) % 2);
            @(negedge clk);
            n_checks++;
            if (dut_vec !== 6'b11_00_1_1 || dut_vec !== model_vec()) begin
                n_err++;
                $display("FAIL bounce_run cyc=%0d got=%b want=%b", i, dut_vec, 6'b11_00_1_1);
            end
        end
    endtask

    task automatic test_button_press();
        int fall_n = -1;
        int rise_n = -1;
        int fe_n = -1;
        ext_rst_n_i = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL press_model edge=%0d got=%b want=%b", n, dut_vec, model_vec());
            end
            if (!core_rst_n_o && !fetch_enable_o && fall_n < 0) fall_n = n;
            if (fall_n > 0 && (core_rst_n_o || fetch_enable_o || rst_cause_o != 2'd2)) begin
                n_err++; $display("FAIL press_held edge=%0d got=%b want=low,cause2", n, dut_vec);
            end
        end
        n_checks++;
        if (fall_n != SYNC + DB + 1) begin
            n_err++; $display("FAIL press_fall got=%0d want=%0d", fall_n, SYNC + DB + 1);
        end
        ext_rst_n_i = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL release_model edge=%0d got=%b want=%b", n, dut_vec, model_vec());
            end
            if (core_rst_n_o && rise_n < 0) rise_n = n;
            if (fetch_enable_o && fe_n < 0) fe_n = n;
        end
        n_checks++;
        if (rise_n != SYNC + DB + HOLD) begin
            n_err++; $display("FAIL release_rst_rise got=%0d want=%0d", rise_n, SYNC + DB + HOLD);
        end
        n_checks++;
        if (fe_n != SYNC + DB + HOLD + FETCH) begin
            n_err++; $display("FAIL release_fetch_rise got=%0d want=%0d", fe_n, SYNC + DB + HOLD + FETCH);
        end
    endtask

    task automatic test_lock_loss();
        int k;
        int rise_n = -1;
        int fe_n = -1;
        sw_rst_req_i = 1'b1;
        @(negedge clk);
        sw_rst_req_i = 1'b0;
        k = 0;
        while (state_o != 2'd2 && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (state_o != 2'd2) begin
            n_err++; $display("FAIL lock_reach_release got=%0d want=2", state_o);
        end
        locked_i = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) locked_i = 1'b1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL lock_model edge=%0d got=%b want=%b", n, dut_vec, model_vec());
            end
            if (n == 3) begin
                n_checks++;
                if (dut_vec !== 6'b00_01_0_0) begin
                    n_err++; $display("FAIL lock_wait_lock got=%b want=%b", dut_vec, 6'b00_01_0_0);
                end
            end
            if (core_rst_n_o && n > 3 && rise_n < 0) rise_n = n;
            if (fetch_enable_o && n > 3 && fe_n < 0) fe_n = n;
        end
        n_checks++;
        if (rise_n != 1 + SYNC + 1 + HOLD || fe_n != 1 + SYNC + 1 + HOLD + FETCH) begin
            n_err++;
            $display("FAIL relock_timing got=%0d/%0d want=%0d/%0d", rise_n, fe_n,
                     1 + SYNC + 1 + HOLD, 1 + SYNC + 1 + HOLD + FETCH);
        end
    endtask

    task automatic test_soft_reset();
        int rise_n = -1;
        int fe_n = -1;
        sw_rst_req_i = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            sw_rst_req_i = (n == 2);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL soft_model edge=%0d got=%b want=%b", n, dut_vec, model_vec());
            end
            if (n == 1) begin
                n_checks++;
                if (dut_vec !== 6'b01_11_0_0) begin
                    n_err++; $display("FAIL soft_enter got=%b want=%b", dut_vec, 6'b01_11_0_0);
                end
            end
            if (core_rst_n_o && n > 1 && rise_n < 0) rise_n = n;
            if (fetch_enable_o && n > 1 && fe_n < 0) fe_n = n;
        end
        n_checks++;
        if (rise_n != 1 + HOLD || fe_n != 1 + HOLD + FETCH) begin
            n_err++;
            $display("FAIL soft_timing got=%0d/%0d want=%0d/%0d", rise_n, fe_n, 1 + HOLD, 1 + HOLD + FETCH);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        locked_i = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            sw_rst_req_i = (n == 2);
        end
        n_checks++;
        if (dut_vec !== 6'b00_01_0_0 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL simul_lock_wins got=%b want=%b", dut_vec, 6'b00_01_0_0);
        end
        locked_i = 1'b1;
        k = 0;
        while (!fetch_enable_o && k < 30) begin @(negedge clk); k++; end
        n_checks++;
        if (dut_vec !== 6'b11_01_1_1) begin
            n_err++; $display("FAIL simul_relock got=%b want=%b", dut_vec, 6'b11_01_1_1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (dut_vec !== 6'b00_00_0_0 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL midrun_reset got=%b want=%b", dut_vec, 6'b00_00_0_0);
        end
    endtask

    task automatic test_random();
        int lock_off = 0;
        int press = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL random_model cyc=%0d got=%b want=%b", c, dut_vec, model_vec());
            end
            n_checks++;
            if (fetch_enable_o && !core_rst_n_o) begin
                n_err++; $display("FAIL random_invariant cyc=%0d got fe=1 rstn=0 want rstn=1", c);
            end
            rst = ($urandom_range(0, 799) == 0);
            sw_rst_req_i = ($urandom_range(0, 24) == 0);
            if (lock_off > 0) lock_off--;
            else if ($urandom_range(0, 249) == 0) lock_off = $urandom_range(1, 5);
            locked_i = (lock_off == 0);
            if (press > 0) press--;
            else if ($urandom_range(0, 149) == 0) press = $urandom_range(1, 40);
            ext_rst_n_i = (press == 0) ? 1'b1 : ((press < 3) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        rst = 1'b0; sw_rst_req_i = 1'b0; locked_i = 1'b1; ext_rst_n_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_boot();
        test_bounce();
        test_button_press();
        test_lock_loss();
        test_soft_reset();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish got=running want=finished");
        $fatal(1);
    end

endmodule
